ema_pulse_burst: RTL and testbench

Parametrised successor to the free-running EMA pulse divider. It generates a complementary EMA_PULSE_P / EMA_PULSE_N burst with these run-time settings:
- carrier half-period
- dead time between the two phases
- number of carrier periods per burst
- hold-off between bursts
- optional automatic repetition

The block sits between the control registers and the differential EMA pulse output pins (68/69). It replaces the fixed counter-bit taps with a controlled, bounded burst.

---
 rtl/ema_pulse_burst.sv | 200 ++++++++++++++++++++
 tb/tb_ema_pulse_burst.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ema_pulse_burst.sv
// Complementary EMA pulse burst generator: P/N carrier phases separated by dead time,
// a bounded number of periods per burst, hold-off between bursts and optional auto-repeat.
module ema_pulse_burst #(
    parameter int unsigned HALF_W = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned REP_W  = 24
) (
    input  logic              CLK_0,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              AUTO,
    input  logic [HALF_W-1:0] HALF_PERIOD,
    input  logic [HALF_W-1:0] DEAD_TIME,
    input  logic [CNT_W-1:0]  NUM_PERIODS,
    input  logic [REP_W-1:0]  HOLDOFF,
    output logic              EMA_PULSE_P,
    output logic              EMA_PULSE_N,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PH_P   = 3'd1;
    localparam logic [2:0] ST_DEAD_P = 3'd2;
    localparam logic [2:0] ST_PH_N   = 3'd3;
    localparam logic [2:0] ST_DEAD_N = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [HALF_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [REP_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HALF_W-1:0] h_q, h_d, d_q, d_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [REP_W-1:0]  r_q, r_d;
    logic              p_q, p_d, n_q, n_d, busy_q, busy_d, done_q, done_d;
    logic              period_end, burst_end, hold_end, launch;

    // Next-state: phase sequencing first, then period/burst/hold-off completion, then (re)launch, STOP last.
    always_comb begin
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        per_cnt_d  = per_cnt_q;
        hold_cnt_d = hold_cnt_q;
        h_d        = h_q;
        d_d        = d_q;
        k_d        = k_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        period_end = 1'b0;
        burst_end  = 1'b0;
        hold_end   = 1'b0;
        launch     = 1'b0;

        case (state_q)
            ST_IDLE: launch = START && !STOP;
            ST_PH_P: begin
                if (ph_cnt_q == h_q - HALF_W'(1)) begin
                    ph_cnt_d = '0;
                    state_d  = (d_q != '0) ? ST_DEAD_P : ST_PH_N;
                end else begin
                    ph_cnt_d = ph_cnt_q + HALF_W'(1);
                end
            end
            ST_DEAD_P: begin
                if (ph_cnt_q == d_q - HALF_W'(1)) begin
                    ph_cnt_d = '0;
                    state_d  = ST_PH_N;
                end else begin
                    ph_cnt_d = ph_cnt_q + HALF_W'(1);
                end
            end
            ST_PH_N: begin
                if (ph_cnt_q == h_q - HALF_W'(1)) begin
                    ph_cnt_d = '0;
                    if (d_q != '0) state_d = ST_DEAD_N;
                    else           period_end = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + HALF_W'(1);
                end
            end
            ST_DEAD_N: begin
                if (ph_cnt_q == d_q - HALF_W'(1)) begin
                    ph_cnt_d   = '0;
                    period_end = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + HALF_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) hold_end = 1'b1;
                else                  hold_cnt_d = hold_cnt_q - REP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Compare before incrementing so the period counter can never wrap.
        if (period_end) begin
            if (per_cnt_q == k_q - CNT_W'(1)) begin
                per_cnt_d = '0;
                burst_end = 1'b1;
            end else begin
                per_cnt_d = per_cnt_q + CNT_W'(1);
                state_d   = ST_PH_P;
            end
        end

        if (burst_end) begin
            done_d = 1'b1;
            if (r_q == '0) begin
                hold_end = 1'b1;
            end else begin
                state_d    = ST_HOLD;
                hold_cnt_d = r_q - REP_W'(1);
            end
        end

        if (hold_end) begin
            if (AUTO) begin
                launch = 1'b1;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end

        // An empty auto-repeating burst parks one cycle in HOLD so relaunch never chains combinationally.
        if (launch) begin
            h_d       = (HALF_PERIOD == '0) ? HALF_W'(1) : HALF_PERIOD;
            d_d       = DEAD_TIME;
            k_d       = NUM_PERIODS;
            r_d       = HOLDOFF;
            busy_d    = 1'b1;
            ph_cnt_d  = '0;
            per_cnt_d = '0;
            if (NUM_PERIODS == '0) begin
                done_d = 1'b1;
                if (HOLDOFF == '0 && !AUTO) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = (HOLDOFF == '0) ? '0 : HOLDOFF - REP_W'(1);
                end
            end else begin
                state_d = ST_PH_P;
            end
        end

        if (STOP && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            ph_cnt_d   = '0;
            per_cnt_d  = '0;
            hold_cnt_d = '0;
        end

        p_d = (state_d == ST_PH_P);
        n_d = (state_d == ST_PH_N);
    end

    always_ff @(posedge CLK_0 or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ph_cnt_q   <= '0;
            per_cnt_q  <= '0;
            hold_cnt_q <= '0;
            h_q        <= '0;
            d_q        <= '0;
            k_q        <= '0;
            r_q        <= '0;
            p_q        <= 1'b0;
            n_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            per_cnt_q  <= per_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            h_q        <= h_d;
            d_q        <= d_d;
            k_q        <= k_d;
            r_q        <= r_d;
            p_q        <= p_d;
            n_q        <= n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign EMA_PULSE_P = p_q;
    assign EMA_PULSE_N = n_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_ema_pulse_burst.sv
// Directed bench for ema_pulse_burst: cycle-exact P/N/BUSY/DONE checks per scenario plus a random reset sweep.
module tb_ema_pulse_burst;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned REP_W  = 24;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              start  = 1'b0;
    logic              stop   = 1'b0;
    logic              auto_m = 1'b0;
    logic [HALF_W-1:0] half_p = '0;
    logic [HALF_W-1:0] dead_t = '0;
    logic [CNT_W-1:0]  num_p  = '0;
    logic [REP_W-1:0]  hold_t = '0;
    logic              p, n, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ema_pulse_burst #(.HALF_W(HALF_W), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .CLK_0       (clk),
        .RST         (rst),
        .START       (start),
        .STOP        (stop),
        .AUTO        (auto_m),
        .HALF_PERIOD (half_p),
        .DEAD_TIME   (dead_t),
        .NUM_PERIODS (num_p),
        .HOLDOFF     (hold_t),
        .EMA_PULSE_P (p),
        .EMA_PULSE_N (n),
        .BUSY        (busy),
        .DONE        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int d, input int k, input int r, input logic a);
        half_p = HALF_W'(h);
        dead_t = HALF_W'(d);
        num_p  = CNT_W'(k);
        hold_t = REP_W'(r);
        auto_m = a;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        tick();
        obs = {p, n, busy, done};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold got=%b want=0000", obs);
        end
        #3 rst = 1'b0;
        tick();
        obs = {p, n, busy, done};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release got=%b want=0000", obs);
        end
    endtask

    task automatic test_basic_burst();
        logic [3:0] obs, want;
        set_cfg(3, 1, 2, 0, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start = 1'b0;
            obs  = {p, n, busy, done};
            want = {(c >= 1 && c <= 3) || (c >= 9 && c <= 11),
                    (c >= 5 && c <= 7) || (c >= 13 && c <= 15),
                    c <= 16, c == 17};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL basic_burst cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_zero_half();
        logic [3:0] obs, want;
        set_cfg(0, 0, 1, 4, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = (c == 4);
            obs  = {p, n, busy, done};
            want = {c == 1, c == 2, c <= 6, c == 3};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL zero_half_holdoff cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_empty_burst();
        logic [3:0] obs, want;
        set_cfg(1, 0, 0, 0, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) set_cfg(1, 0, 1, 0, 1'b0);
            if (c == 2) start = 1'b0;
            obs  = {p, n, busy, done};
            want = {c == 2, c == 3, c == 2 || c == 3, c == 1 || c == 4};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL empty_burst cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_stop();
        logic [3:0] obs, want;
        set_cfg(2, 2, 5, 0, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start = (c == 11) || (c == 15);
            stop  = (c == 10) || (c == 14) || (c == 15);
            obs  = {p, n, busy, done};
            want = {(c >= 1 && c <= 2) || (c >= 9 && c <= 10) || (c >= 12 && c <= 13),
                    c >= 5 && c <= 6,
                    c <= 10 || (c >= 12 && c <= 14),
                    1'b0};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL stop_abort cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_auto_repeat();
        logic [3:0] obs, want;
        set_cfg(1, 0, 1, 2, 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            if (c == 12) begin
                stop   = 1'b1;
                auto_m = 1'b0;
            end else begin
                stop = 1'b0;
            end
            want = (c == 13) ? 4'b0000 :
                   {c % 4 == 1, c % 4 == 2, 1'b1, c % 4 == 3};
            obs  = {p, n, busy, done};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL auto_repeat cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, want;
        set_cfg(1, 1, 1, 0, 1'b1);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c == 9) begin
                stop   = 1'b1;
                auto_m = 1'b0;
            end else begin
                stop = 1'b0;
            end
            want = (c == 10) ? 4'b0000 :
                   {c % 4 == 1, c % 4 == 3, 1'b1, c >= 5 && c % 4 == 1};
            obs  = {p, n, busy, done};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL back_to_back cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_max_count();
        logic [3:0] obs, want;
        set_cfg(0, 0, 255, 0, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 512; c++) begin
            tick();
            start = 1'b0;
            obs  = {p, n, busy, done};
            want = {c <= 510 && c % 2 == 1, c <= 510 && c % 2 == 0, c <= 510, c == 511};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL max_count cycle=%0d got=%b want=%b", c, obs, want);
            end
        end
    endtask

    task automatic test_random_reset();
        logic [3:0] obs;
        int len;
        for (int it = 0; it < 12; it++) begin
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            start = 1'b1;
            len = int'($urandom_range(3, 30));
            for (int c = 1; c <= len; c++) begin
                tick();
                start = ($urandom_range(0, 7) == 0);
                stop  = ($urandom_range(0, 15) == 0);
                total++;
                if ((p & n) !== 1'b0) begin
                    bad++;
                    $display("FAIL overlap iter=%0d cycle=%0d got P=%b N=%b want not both 1", it, c, p, n);
                end
            end
            start = 1'b0;
            stop  = 1'b0;
            #3 rst = 1'b1;
            #1;
            obs = {p, n, busy, done};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL async_reset iter=%0d got=%b want=0000", it, obs);
            end
            #2 rst = 1'b0;
        end
        auto_m = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_zero_half();
        test_empty_burst();
        test_stop();
        test_auto_repeat();
        test_back_to_back();
        test_max_count();
        test_random_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
